// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision constants and the fp_div FSM state type.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } state_e;

endpackage

// File: rtl/fp_div_if.sv
// fp_div_if: request/result bundle of the floating-point divider.
// The master issues operands and start; the slave returns status and quotient.
interface fp_div_if;

  logic        start;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        busy;
  logic        done;
  logic [31:0] c_out;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  modport master (
    output start, a_s, b_s,
    input  busy, done, c_out,
    input  overflow, underflow, div_by_zero
  );

  modport slave (
    input  start, a_s, b_s,
    output busy, done, c_out,
    output overflow, underflow, div_by_zero
  );

endinterface

// File: rtl/unsigned_seq_divider.sv
// unsigned_seq_divider: restoring divider, floor(a*2^(N_Q-1)/b), one bit per cycle.
// The first bit is resolved on the start edge, so done follows N_Q-1 edges later.
module unsigned_seq_divider
  import fp_pkg::*;
#(
  parameter int W   = MANT_W,
  parameter int N_Q = 26
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [N_Q-1:0] quotient_o,
  output logic [W-1:0]   remainder_o,
  output logic           done_o
);

  localparam int CW = $clog2(N_Q + 1);
  localparam logic [CW-1:0] LAST = CW'(N_Q - 1);

  logic [W:0]     r_q, r_d;
  logic [W-1:0]   b_q, b_d;
  logic [N_Q-1:0] q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           done_q, done_d;

  logic [W:0]   r_cur, r_nxt;
  logic [W-1:0] b_cur;
  logic         ge;

  // The remainder register holds the partial remainder pre-shifted for the next step.
  always_comb begin
    r_cur = start_i ? {1'b0, a_i} : r_q;
    b_cur = start_i ? b_i : b_q;
    ge    = r_cur >= {1'b0, b_cur};
    r_nxt = ge ? ((r_cur - {1'b0, b_cur}) << 1) : (r_cur << 1);
  end

  always_comb begin
    r_d    = r_q;
    b_d    = b_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start_i) begin
      r_d    = r_nxt;
      b_d    = b_i;
      q_d    = {{(N_Q-1){1'b0}}, ge};
      cnt_d  = CW'(1);
      run_d  = (N_Q > 1);
      done_d = (N_Q == 1);
    end else if (run_q) begin
      r_d   = r_nxt;
      q_d   = {q_q[N_Q-2:0], ge};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q    <= '0;
      b_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      b_q    <= b_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient_o  = q_q;
  assign remainder_o = r_q[W:1];
  assign done_o      = done_q;

endmodule

// File: rtl/fp_div.sv
// fp_div: IEEE-754 single divider, IDLE->DIV->NORM->DONE, fixed 28-cycle latency.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the result truncates.
module fp_div
  import fp_pkg::*;
#(
  parameter int N_Q = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_s,
  input  logic [31:0] b_s,
  output logic        busy,
  output logic        done,
  output logic [31:0] c_out,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

`ifdef FP_DIV_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  state_e state_q, state_d;
  logic   ld, norm_en, fin_en;

  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  ea_q, ea_d;
  logic [EXP_W-1:0]  eb_q, eb_d;
  logic [FRAC_W-1:0] mant_q, mant_d;
  logic              inc_q, inc_d;
  logic signed [9:0] exp_q, exp_d;
  logic [31:0]       c_q, c_d;
  logic              ov_q, ov_d;
  logic              un_q, un_d;
  logic              dz_q, dz_d;
  logic              done_q, done_d;

  logic [N_Q-1:0]    quo;
  logic [MANT_W-1:0] rem;
  logic              div_done;

  logic signed [9:0] e_raw, e_r;
  logic [FRAC_W-1:0] m_n, m_r;
  logic              g_n, s_n, carry;
  logic              az, bz, nz;
  logic [31:0]       res;
  logic              r_ov, r_un, r_dz;

  unsigned_seq_divider #(
    .W   (MANT_W),
    .N_Q (N_Q)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (ld),
    .a_i         ({1'b1, a_s[FRAC_W-1:0]}),
    .b_i         ({1'b1, b_s[FRAC_W-1:0]}),
    .quotient_o  (quo),
    .remainder_o (rem),
    .done_o      (div_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DIV;
      DIV:     if (div_done) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld      = (state_q == IDLE) && start;
    norm_en = (state_q == NORM);
    fin_en  = (state_q == DONE);
    busy    = (state_q != IDLE);
  end

  // Quotient lies in [2^24, 2^26); the top bit picks the normalising shift.
  always_comb begin
    e_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'(BIAS);
    if (quo[25]) begin
      m_n = quo[24:2];
      g_n = quo[1];
      s_n = quo[0] | (|rem);
    end else begin
      m_n = quo[23:1];
      g_n = quo[0];
      s_n = |rem;
    end
  end

  always_comb begin
    {carry, m_r} = {1'b0, mant_q} + {{FRAC_W{1'b0}}, inc_q};
    e_r = exp_q + $signed({9'd0, carry});
    az  = (ea_q == '0);
    bz  = (eb_q == '0);
    nz  = !az && !bz;
    res  = {sign_q, e_r[7:0], m_r};
    r_ov = 1'b0;
    r_un = 1'b0;
    r_dz = 1'b0;
    unique case (1'b1)
      az && bz: begin
        res  = QNAN;
        r_dz = 1'b1;
      end
      bz && !az: begin
        res  = {sign_q, 8'hFF, 23'h0};
        r_dz = 1'b1;
      end
      az && !bz: res = {sign_q, 31'h0};
      nz && (e_r >= 10'sd255): begin
        res  = {sign_q, 8'hFF, 23'h0};
        r_ov = 1'b1;
      end
      nz && (e_r <= 10'sd0): begin
        res  = {sign_q, 31'h0};
        r_un = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sign_d = sign_q;
    ea_d   = ea_q;
    eb_d   = eb_q;
    mant_d = mant_q;
    inc_d  = inc_q;
    exp_d  = exp_q;
    c_d    = c_q;
    ov_d   = ov_q;
    un_d   = un_q;
    dz_d   = dz_q;
    done_d = fin_en;
    if (ld) begin
      sign_d = a_s[31] ^ b_s[31];
      ea_d   = a_s[30:23];
      eb_d   = b_s[30:23];
    end
    if (norm_en) begin
      mant_d = m_n;
      exp_d  = quo[25] ? e_raw : e_raw - 10'sd1;
      inc_d  = RoundEn & g_n & (s_n | m_n[0]);
    end
    if (fin_en) begin
      c_d  = res;
      ov_d = r_ov;
      un_d = r_un;
      dz_d = r_dz;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sign_q <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      mant_q <= '0;
      inc_q  <= 1'b0;
      exp_q  <= '0;
      c_q    <= '0;
      ov_q   <= 1'b0;
      un_q   <= 1'b0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
      ea_q   <= ea_d;
      eb_q   <= eb_d;
      mant_q <= mant_d;
      inc_q  <= inc_d;
      exp_q  <= exp_d;
      c_q    <= c_d;
      ov_q   <= ov_d;
      un_q   <= un_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  assign done        = done_q;
  assign c_out       = c_q;
  assign overflow    = ov_q;
  assign underflow   = un_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: directed and randomized checks of fp_div against an integer reference model.
// Expected rounding follows FP_DIV_ROUND_EN as defined for the build.
module tb_fp_div;
  import fp_pkg::*;

`ifdef FP_DIV_ROUND_EN
  localparam bit RND = 1'b1;
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam bit RND = 1'b0;
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fp_div_if bus ();

  always #5 clk = ~clk;

  fp_div #(.N_Q(26)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (bus.start),
    .a_s         (bus.a_s),
    .b_s         (bus.b_s),
    .busy        (bus.busy),
    .done        (bus.done),
    .c_out       (bus.c_out),
    .overflow    (bus.overflow),
    .underflow   (bus.underflow),
    .div_by_zero (bus.div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, req);
    end
  endtask

  // Reference: exact integer quotient, then the IEEE packing rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic [2:0] fl);
    logic s, g, st;
    int ea, eb, e;
    longint unsigned num, den, q, r;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = {24'd0, a[30:23]};
    eb = {24'd0, b[30:23]};
    c  = '0;
    fl = '0;
    if (ea == 0 && eb == 0) begin
      c  = QNAN;
      fl = 3'b001;
    end else if (eb == 0) begin
      c  = {s, 8'hFF, 23'h0};
      fl = 3'b001;
    end else if (ea == 0) begin
      c = {s, 31'h0};
    end else begin
      num = 64'({1'b1, a[22:0]}) << 25;
      den = 64'({1'b1, b[22:0]});
      q   = num / den;
      r   = num % den;
      e   = ea - eb + 127;
      if (q >= (64'd1 << 25)) begin
        m  = 23'(q >> 2);
        g  = q[1];
        st = q[0] || (r != 0);
      end else begin
        m  = 23'(q >> 1);
        g  = q[0];
        st = (r != 0);
        e  = e - 1;
      end
      if (RND && g && (st || m[0])) begin
        if (m == 23'h7FFFFF) begin
          m = '0;
          e = e + 1;
        end else begin
          m = m + 23'd1;
        end
      end
      if (e >= 255) begin
        c  = {s, 8'hFF, 23'h0};
        fl = 3'b100;
      end else if (e <= 0) begin
        c  = {s, 31'h0};
        fl = 3'b010;
      end else begin
        c = {s, e[7:0], m};
      end
    end
  endfunction

  // Issues one request and counts edges after the start-sampling edge until done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int poke, output int lat);
    lat = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_s   = a;
    bus.b_s   = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.start = (k == poke);
      bus.a_s   = $urandom;
      bus.b_s   = $urandom;
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic op_check(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input int poke,
                          input logic [31:0] c, input logic [2:0] fl);
    int lat;
    run_op(a, b, poke, lat);
    chk({tag, ".latency"}, 32'(lat), 32'd28);
    chk({tag, ".c_out"}, bus.c_out, c);
    chk({tag, ".flags"},
        {29'd0, bus.overflow, bus.underflow, bus.div_by_zero},
        {29'd0, fl});
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 2) == 0) v[30:23] = 8'(110 + $urandom_range(0, 34));
    if ($urandom_range(0, 11) == 0) v[30:23] = 8'd0;
    return v;
  endfunction

  initial begin
    logic [31:0] a, b, c;
    logic [2:0]  fl;
    int          n, poke;

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a_s   = '0;
    bus.b_s   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.c_out", bus.c_out, 32'd0);
    chk("reset.flags",
        {29'd0, bus.overflow, bus.underflow, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    op_check("six_by_two", 32'h40C00000, 32'h40000000, 0, 32'h40400000, 3'b000);
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("hold.c_out", bus.c_out, 32'h40400000);

    op_check("one_third", 32'h3F800000, 32'h40400000, 0, THIRD, 3'b000);
    op_check("neg_by_zero", 32'hC0000000, 32'h00000000, 0, 32'hFF800000, 3'b001);
    op_check("zero_by_zero", 32'h00000000, 32'h00000000, 0, 32'h7FC00000, 3'b001);
    op_check("zero_by_one", 32'h80000000, 32'h3F800000, 0, 32'h80000000, 3'b000);
    op_check("underflow", 32'h00800000, 32'h40000000, 0, 32'h00000000, 3'b010);
    op_check("restart_ignored", 32'h40C00000, 32'h40000000, 5, 32'h40400000, 3'b000);
    op_check("overflow", 32'h7F000000, 32'h3E800000, 0, 32'h7F800000, 3'b100);

    // Abort an operation in flight with reset on the tenth edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_s   = 32'h3F800000;
    bus.b_s   = 32'h40400000;
    @(posedge clk);
    #1;
    chk("abort.busy_on", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.c_out", bus.c_out, 32'd0);
    chk("abort.flags",
        {29'd0, bus.overflow, bus.underflow, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) n++;
    end
    chk("abort.no_done", 32'(n), 32'd0);
    chk("abort.c_out_after", bus.c_out, 32'd0);
    op_check("after_abort", 32'h40C00000, 32'h40000000, 0, 32'h40400000, 3'b000);

    for (int i = 0; i < 24; i++) begin
      a    = rnd_operand();
      b    = rnd_operand();
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
      ref_div(a, b, c, fl);
      op_check($sformatf("rand%0d", i), a, b, poke, c, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-low reset (0 = reset).
REQ-003 SHALL have ports: start  in  1  request; sampled only in IDLE.
REQ-004 SHALL have ports: a_s  in  32  IEEE-754 single dividend.
REQ-005 SHALL have ports: b_s  in  32  IEEE-754 single divisor.
REQ-006 SHALL have ports: busy  out  1  high while an operation is in flight.
REQ-007 SHALL have ports: done  out  1  one-cycle pulse, c_out and flags valid.
REQ-008 SHALL have ports: c_out  out  32  quotient a_s/b_s, held until the next done.
REQ-009 SHALL have ports: overflow, underflow, div_by_zero  out  1 each  status flags, updated only with done.
REQ-010 SHALL have parameter: N_Q, default 26, quotient bits produced by the iterative divider.

Function
REQ-011 SHALL use FSM states IDLE -> DIV -> NORM -> DONE -> IDLE.
REQ-012 SHALL latch a_s and b_s, assert busy, and enter DIV on the edge where start=1 in IDLE.
REQ-013 SHALL ignore start while busy=1; latched operands SHALL NOT change.
REQ-014 SHALL make the sign sign_a XOR sign_b and the exponent e = exp_a - exp_b + 127, computed in 10-bit signed arithmetic.
REQ-015 SHALL make mantissas {1, frac}, 24 bits; DIV SHALL compute Q = floor(mant_a*2^25 / mant_b) by restoring division, 1 bit per cycle, for N_Q = 26 cycles, keeping the remainder.
REQ-016 SHALL normalize in NORM: if Q[25]=1, then mant=Q[24:2], guard=Q[1], sticky=Q[0] OR (rem!=0), exponent e; otherwise mant=Q[23:1], guard=Q[0], sticky=(rem!=0), exponent e-1.
REQ-017 SHALL treat an operand with exponent 0 as signed zero (denormals flushed); an exponent of 255 is not special-cased.
REQ-018 SHALL, for a_exp=0 and b_exp!=0, give c_out={sign, 31'b0} with all flags 0.
REQ-019 SHALL, for b_exp=0 and a_exp!=0, give c_out={sign, 8'hFF, 23'h0} and div_by_zero=1.
REQ-020 SHALL, for both exponents 0, give c_out=32'h7FC00000 and div_by_zero=1.
REQ-021 SHALL, when the final exponent is >=255, give c_out={sign, 8'hFF, 23'h0} and overflow=1.
REQ-022 SHALL, when the final exponent is <=0, give c_out={sign, 31'b0} and underflow=1.
REQ-023 SHALL still run the full DIV length on zero and special cases, so latency is data-independent.
REQ-024 SHALL, in DONE, register c_out and the flags, pulse done for 1 cycle, and deassert busy in the same cycle; done occurs exactly 28 edges after the start-sampling edge.
REQ-025 SHALL accept start again in the cycle after done, giving back-to-back throughput of 1 result per 29 cycles.

Reset
REQ-026 SHALL, while rst=0 on a clock edge, force FSM=IDLE, busy=0, done=0, c_out=0, and overflow/underflow/div_by_zero=0.
REQ-027 SHALL make a reset during DIV or NORM abort the operation with no done pulse, leaving no stale result visible.

Configuration
REQ-028 SHALL, with macro FP_DIV_ROUND_EN defined, round to nearest even: increment mant if guard AND (sticky OR mant[0]); mantissa carry-out SHALL zero mant and add 1 to the exponent, with the overflow check after rounding.
REQ-029 SHALL, without FP_DIV_ROUND_EN, truncate (guard and sticky ignored), with timing identical to the rounding build.

Structure
REQ-030 SHALL place in shared package fp_pkg: EXP_W=8, FRAC_W=23, BIAS=127, QNAN=32'h7FC00000, and the FSM state enum type.
REQ-031 SHALL place the iterative restoring divider in sub-module unsigned_seq_divider (start, N_Q-bit quotient, remainder, done); fp_div holds sign/exponent/special-case/normalize/round logic and the FSM.

Verification
REQ-032 SHALL verify: a_s=40C00000, b_s=40000000 -> c_out=40400000, all flags 0, done 28 edges after start.
REQ-033 SHALL verify: a_s=3F800000, b_s=40400000 -> c_out=3EAAAAAB with FP_DIV_ROUND_EN, 3EAAAAAA without.
REQ-034 SHALL verify: a_s=C0000000, b_s=00000000 -> c_out=FF800000, div_by_zero=1; a_s=b_s=0 -> 7FC00000, div_by_zero=1.
REQ-035 SHALL verify: a_s=7F000000, b_s=3E800000 -> c_out=7F800000, overflow=1; a_s=00800000, b_s=40000000 -> c_out=00000000, underflow=1.
REQ-036 SHALL verify: start re-pulsed with new operands mid-DIV -> ignored, the original result is returned; rst=0 at cycle 10 -> no done, outputs 0, and the next start computes correctly.
